// File: rtl/dyn_mem_bank_group_responder.sv
// Bank-group endpoint for the TCDM interface. It serves one bank group from a
// byte-parity-protected array and answers every accepted request exactly one
// cycle later. After reset it zero-fills the array, counts responses that carry
// a parity error, and can deliberately corrupt stored parity to exercise that
// error path.
module dyn_mem_bank_group_responder #(
  parameter int DATA_WIDTH    = 64,
  parameter int ADDR_WIDTH    = 10,
  parameter bit INIT_ON_RESET = 1'b1,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    tcdm_req_i,
  input  logic [ADDR_WIDTH-1:0]   tcdm_addr_i,
  input  logic                    tcdm_we_i,
  input  logic [DATA_WIDTH/8-1:0] tcdm_strb_i,
  input  logic [DATA_WIDTH-1:0]   tcdm_wdata_i,
  output logic                    tcdm_gnt_o,
  output logic                    tcdm_rvalid_o,
  output logic [DATA_WIDTH-1:0]   tcdm_rdata_o,
  output logic                    tcdm_ecc_err_o,
  input  logic                    err_inject_i,
  output logic                    init_done_o,
  output logic [CNT_WIDTH-1:0]    err_cnt_o
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;
  localparam int NUM_WORDS = 2 ** ADDR_WIDTH;

  typedef enum logic {
    ST_INIT,
    ST_READY
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   init_cnt_q, init_cnt_d;

  logic [DATA_WIDTH-1:0]   mem_data [NUM_WORDS];
  logic [NUM_BYTES-1:0]    mem_par  [NUM_WORDS];

  logic                    accept;
  logic [NUM_BYTES-1:0]    mem_be;
  logic [ADDR_WIDTH-1:0]   mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [NUM_BYTES-1:0]    mem_wpar;

  logic [DATA_WIDTH-1:0]   rd_word;
  logic [NUM_BYTES-1:0]    rd_par;
  logic                    rd_err;

  logic                    rvalid_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic                    ecc_q;
  logic [CNT_WIDTH-1:0]    err_cnt_q;

  // State and init-counter register; reset always restarts the sweep at word 0.
  // NOTE: every register is written with <= so all flops update on the same edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= INIT_ON_RESET ? ST_INIT : ST_READY;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  // Next state: step through every word once, then stay READY until reset.
  // NOTE: defaults first so no path leaves a signal unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    if (state_q == ST_INIT) begin
      init_cnt_d = init_cnt_q + 1'b1;
      if (&init_cnt_q) state_d = ST_READY;
    end
  end

  // The grant is held low while reset is active, even when READY is the reset state.
  assign tcdm_gnt_o  = (state_q == ST_READY) & ~rst_i;
  assign init_done_o = tcdm_gnt_o;
  assign accept      = tcdm_req_i & tcdm_gnt_o;

  // Select the single write port: the zero-fill sweep during INIT, or an accepted write.
  always_comb begin
    mem_be    = '0;
    mem_addr  = tcdm_addr_i;
    mem_wdata = tcdm_wdata_i;
    mem_wpar  = '0;
    if (state_q == ST_INIT) begin
      mem_be    = '1;
      mem_addr  = init_cnt_q;
      mem_wdata = '0;
    end else if (accept && tcdm_we_i) begin
      mem_be = tcdm_strb_i;
      for (int b = 0; b < NUM_BYTES; b++) begin
        mem_wpar[b] = (^tcdm_wdata_i[8*b +: 8]) ^ err_inject_i;
      end
    end
  end

  // Byte-masked array update. Data and parity are written only where the byte enable is set.
  // NOTE: the array is deliberately not reset; the INIT sweep zero-fills it instead.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < NUM_BYTES; b++) begin
      if (mem_be[b]) begin
        mem_data[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        mem_par[mem_addr][b]         <= mem_wpar[b];
      end
    end
  end

  assign rd_word = mem_data[tcdm_addr_i];
  assign rd_par  = mem_par[tcdm_addr_i];

  // Parity check of the addressed word: any byte whose stored parity disagrees flags an error.
  always_comb begin
    rd_err = 1'b0;
    for (int b = 0; b < NUM_BYTES; b++) begin
      rd_err = rd_err | (rd_par[b] ^ (^rd_word[8*b +: 8]));
    end
  end

  // One-cycle response. Read data and the parity flag are forced to zero on write responses and idle cycles.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      ecc_q    <= 1'b0;
    end else begin
      rvalid_q <= accept;
      rdata_q  <= (accept && !tcdm_we_i) ? rd_word : '0;
      ecc_q    <= accept && !tcdm_we_i && rd_err;
    end
  end

  // Saturating error counter. It increments at the end of each cycle that carries an erroneous response.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_cnt_q <= '0;
    end else if (rvalid_q && ecc_q && !(&err_cnt_q)) begin
      err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign tcdm_rvalid_o  = rvalid_q;
  assign tcdm_rdata_o   = rdata_q;
  assign tcdm_ecc_err_o = ecc_q;
  assign err_cnt_o      = err_cnt_q;

endmodule

// File: tb/tb_dyn_mem_bank_group_responder.sv
// Testbench for dyn_mem_bank_group_responder. It drives two instances that
// differ only in counter width. A word/byte-level model predicts every cycle's
// outputs, and directed literal expectations pin the key scenarios.
module tb_dyn_mem_bank_group_responder;

  localparam int DW = 64;
  localparam int AW = 4;
  localparam int NW = 16;
  localparam int NB = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req = 1'b0;
  logic          we = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [NB-1:0] strb = '0;
  logic [DW-1:0] wdata = '0;
  logic          inj = 1'b0;

  logic          gnt, rvalid, ecc, init_done;
  logic [DW-1:0] rdata;
  logic [15:0]   err_cnt;
  logic          s_gnt, s_rvalid, s_ecc, s_init_done;
  logic [DW-1:0] s_rdata;
  logic [1:0]    s_err_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dyn_mem_bank_group_responder #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .INIT_ON_RESET(1'b1), .CNT_WIDTH(16)
  ) dut (
    .clk_i(clk), .rst_i(rst), .tcdm_req_i(req), .tcdm_addr_i(addr),
    .tcdm_we_i(we), .tcdm_strb_i(strb), .tcdm_wdata_i(wdata),
    .tcdm_gnt_o(gnt), .tcdm_rvalid_o(rvalid), .tcdm_rdata_o(rdata),
    .tcdm_ecc_err_o(ecc), .err_inject_i(inj), .init_done_o(init_done),
    .err_cnt_o(err_cnt)
  );

  dyn_mem_bank_group_responder #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .INIT_ON_RESET(1'b1), .CNT_WIDTH(2)
  ) dut_sat (
    .clk_i(clk), .rst_i(rst), .tcdm_req_i(req), .tcdm_addr_i(addr),
    .tcdm_we_i(we), .tcdm_strb_i(strb), .tcdm_wdata_i(wdata),
    .tcdm_gnt_o(s_gnt), .tcdm_rvalid_o(s_rvalid), .tcdm_rdata_o(s_rdata),
    .tcdm_ecc_err_o(s_ecc), .err_inject_i(inj), .init_done_o(s_init_done),
    .err_cnt_o(s_err_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the array holds plain data, and each byte carries a "corrupted" flag.
  logic [DW-1:0] m_data [NW];
  logic [NB-1:0] m_bad  [NW];
  int            m_edges = 0;
  bit            m_acc;
  bit            e_rvalid = 1'b0;
  bit            e_ecc = 1'b0;
  logic [DW-1:0] e_rdata = '0;
  int            e_cnt16 = 0;
  int            e_cnt2 = 0;
  bit            model_live = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_edges  = 0;
      e_rvalid = 1'b0;
      e_rdata  = '0;
      e_ecc    = 1'b0;
      e_cnt16  = 0;
      e_cnt2   = 0;
      for (int i = 0; i < NW; i++) begin
        m_data[i] = '0;
        m_bad[i]  = '0;
      end
      model_live = 1'b1;
    end else begin
      if (e_rvalid && e_ecc) begin
        if (e_cnt16 < 65535) e_cnt16++;
        if (e_cnt2 < 3) e_cnt2++;
      end
      m_acc    = req && (m_edges >= NW);
      e_rvalid = m_acc;
      e_rdata  = '0;
      e_ecc    = 1'b0;
      if (m_acc && we) begin
        for (int b = 0; b < NB; b++) begin
          if (strb[b]) begin
            m_data[addr][8*b +: 8] = wdata[8*b +: 8];
            m_bad[addr][b]         = inj;
          end
        end
      end else if (m_acc) begin
        e_rdata = m_data[addr];
        e_ecc   = |m_bad[addr];
      end
      if (m_edges < NW) m_edges++;
    end
  end

  // Cycle-by-cycle comparison against the model, just after each active edge.
  always @(posedge clk) begin
    #1;
    if (model_live) begin
      check("gnt",         gnt,       64'(m_edges >= NW));
      check("init_done",   init_done, 64'(m_edges >= NW));
      check("rvalid",      rvalid,    64'(e_rvalid));
      check("rdata",       rdata,     e_rdata);
      check("ecc_err",     ecc,       64'(e_ecc));
      check("err_cnt",     err_cnt,   64'(e_cnt16));
      check("sat_rvalid",  s_rvalid,  64'(e_rvalid));
      check("sat_err_cnt", s_err_cnt, 64'(e_cnt2));
    end
  end

  task automatic op(input bit r, input bit w, input int a, input logic [7:0] s,
                    input logic [63:0] d, input bit i);
    req   = r;
    we    = w;
    addr  = a[AW-1:0];
    strb  = s;
    wdata = d;
    inj   = i;
    @(negedge clk);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (gnt !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  int n;
  int sat_exp [5] = '{1, 2, 3, 3, 3};

  initial begin
    repeat (3) @(negedge clk);
    // Hold a read of addr 5 through INIT; it must wait until the grant comes up.
    req  = 1'b1;
    we   = 1'b0;
    addr = 4'd5;
    rst  = 1'b0;
    wait_ready(n);
    check("init_cycles", 64'(n), 64'd16);
    @(negedge clk);
    check("first_read_rvalid", rvalid, 1);
    check("first_read_rdata",  rdata, 0);
    check("first_read_ecc",    ecc, 0);

    // Full write followed back to back by a read of the same address.
    op(1, 1, 3, 8'hFF, 64'h1122334455667788, 0);
    check("wr_rvalid", rvalid, 1);
    check("wr_rdata",  rdata, 0);
    op(1, 0, 3, 8'h00, 64'h0, 0);
    check("rd_full", rdata, 64'h1122334455667788);

    // Partial write over the low half.
    op(1, 1, 3, 8'h0F, 64'hAAAAAAAABBBBBBBB, 0);
    op(1, 0, 3, 8'h00, 64'h0, 0);
    check("rd_partial",     rdata, 64'h11223344BBBBBBBB);
    check("rd_partial_ecc", ecc, 0);

    // Inject on a read and on a zero-strobe write must not disturb the stored word.
    op(1, 0, 3, 8'h00, 64'h0, 1);
    op(1, 1, 3, 8'h00, 64'hFFFFFFFFFFFFFFFF, 1);
    op(1, 0, 3, 8'h00, 64'h0, 0);
    check("rd_after_noop",     rdata, 64'h11223344BBBBBBBB);
    check("rd_after_noop_ecc", ecc, 0);

    // Injected parity error on byte 0 of addr 7, read twice.
    op(1, 1, 7, 8'h01, 64'h5A, 1);
    op(1, 0, 7, 8'h00, 64'h0, 0);
    check("inj_ecc_1", ecc, 1);
    op(1, 0, 7, 8'h00, 64'h0, 0);
    check("inj_ecc_2", ecc, 1);
    op(0, 0, 0, 8'h00, 64'h0, 0);
    check("inj_err_cnt",     err_cnt, 2);
    check("inj_sat_err_cnt", s_err_cnt, 2);

    // A clean rewrite of the same byte clears the error.
    op(1, 1, 7, 8'h01, 64'h5B, 0);
    op(1, 0, 7, 8'h00, 64'h0, 0);
    check("fix_rdata", rdata, 64'h5B);
    check("fix_ecc",   ecc, 0);
    op(0, 0, 0, 8'h00, 64'h0, 0);
    check("fix_err_cnt", err_cnt, 2);

    // Reset, then reset again at INIT counter 8. The sweep must restart and take a full 16 cycles.
    req  = 1'b1;
    we   = 1'b0;
    addr = 4'd3;
    rst  = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wait_ready(n);
    check("reinit_cycles", 64'(n), 64'd16);
    @(negedge clk);
    check("reinit_rvalid",  rvalid, 1);
    check("reinit_rdata",   rdata, 0);
    check("reinit_err_cnt", err_cnt, 0);

    // Saturation of the 2-bit counter over five erroneous reads.
    op(1, 1, 9, 8'h80, 64'hC300000000000000, 1);
    for (int k = 0; k < 5; k++) begin
      op(1, 0, 9, 8'h00, 64'h0, 0);
      check("sat_rd_ecc", ecc, 1);
      op(0, 0, 0, 8'h00, 64'h0, 0);
      check("sat_seq", s_err_cnt, 64'(sat_exp[k]));
    end
    check("wide_err_cnt", err_cnt, 5);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
